snes_mem_responder: RTL and testbench
=====================================

// Module: snes_mem_responder
// PURPOSE
//  Bus-cycle responder behind the SNES address decoder.
//  Converts decoded SNES read/write strobes into single-beat requests on the SRAM0 memory-controller handshake.
//  Returns read data to the SNES data-bus driver.
//  Sits between the decoder outputs (ROM_ADDR/ROM_HIT/IS_WRITABLE) and the SRAM0 controller port.
// PARAMETERS
//  TIMEOUT_CYCLES   32     max CLK cycles MEM_REQ may stay high without MEM_ACK (MEM_TIMEOUT_EN only)
//  OPEN_BUS_VALUE   8'hFF  data returned to SNES on a timed-out read (MEM_TIMEOUT_EN only)
// PORTS
//  CLK           in   1   system clock; all logic on rising edge
//  RST_N         in   1   asynchronous, active-low reset
//  SNES_RD_N     in   1   SNES read strobe, already synchronised to CLK
//  SNES_WR_N     in   1   SNES write strobe, already synchronised to CLK
//  SNES_DIN      in   8   SNES write data
//  ROM_ADDR      in   24  decoded physical address
//  ROM_HIT       in   1   decoded address maps to SRAM0 (ROM or save RAM)
//  IS_WRITABLE   in   1   decoded address is writable save RAM
//  MEM_REQ       out  1   request to memory controller, level
//  MEM_WE        out  1   1=write, 0=read; valid while MEM_REQ
//  MEM_ADDR      out  24  latched request address
//  MEM_WDATA     out  8   latched write data
//  MEM_ACK       in   1   one-cycle completion pulse from controller
//  MEM_RDATA     in   8   read data, valid with MEM_ACK
//  SNES_DOUT     out  8   data for SNES bus driver
//  SNES_DOUT_EN  out  1   drive SNES_DOUT onto bus
//  BUSY          out  1   state != IDLE
//  TIMEOUT_FLAG  out  1   sticky timeout indicator
// BEHAVIOUR
//  - Reset (async): all outputs 0; state IDLE; edge regs rd_n_d = wr_n_d = 1. Reset mid-transaction drops MEM_REQ immediately; the controller tolerates this.
//  - Edge detect: fall = d & ~cur, rise = ~d & cur, per strobe, registered each cycle.
//  - States: IDLE, RD_REQ, RD_HOLD, WR_WAIT, WR_REQ.
//  - IDLE, RD fall & ROM_HIT: latch MEM_ADDR <= ROM_ADDR; MEM_REQ = 1, MEM_WE = 0 from the next cycle; go to RD_REQ.
//  - IDLE, RD fall & ~ROM_HIT: no request, stay in IDLE, DOUT_EN stays 0.
//  - IDLE, WR fall & IS_WRITABLE: latch MEM_ADDR; go to WR_WAIT. A write miss is ignored.
//  - RD fall and WR fall in the same cycle: read wins; the write is dropped.
//  - RD_REQ: hold MEM_REQ until MEM_ACK is sampled. Deassert MEM_REQ the cycle after the ACK cycle; the ACK cycle itself sees MEM_REQ = 1.
//  - RD_REQ, MEM_ACK: SNES_DOUT <= MEM_RDATA, SNES_DOUT_EN <= 1; go to RD_HOLD. Latency: RD fall sampled at cycle 0 -> MEM_REQ at cycle 1 -> ACK at cycle n -> DOUT_EN at cycle n+1.
//  - RD_REQ, RD_N rises before ACK: the transaction still completes. Data is discarded, DOUT_EN is never asserted, return to IDLE on ACK.
//  - RD_HOLD: keep DOUT/DOUT_EN until RD rise; then DOUT_EN = 0 and go to IDLE. SNES_DOUT retains its last value.
//  - WR_WAIT: on WR rise, MEM_WDATA <= SNES_DIN; MEM_REQ = 1, MEM_WE = 1 next cycle; go to WR_REQ. Data is sampled at the rise because SNES write data is valid late.
//  - WR_REQ: hold until MEM_ACK, then IDLE. No SNES data drive on writes.
//  - Edges arriving in states that do not expect them are ignored; no queueing. A new RD fall is honoured only once back in IDLE.
//  - MEM_ADDR/MEM_WE/MEM_WDATA stay stable for the whole MEM_REQ interval.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined: a counter of width clog2(TIMEOUT_CYCLES+1) clears on each REQ assertion and counts cycles with MEM_REQ = 1 and no ACK.
//    - When the count reaches TIMEOUT_CYCLES: MEM_REQ drops and TIMEOUT_FLAG is set, sticky until reset.
//    - Timed-out read with RD_N still low: SNES_DOUT <= OPEN_BUS_VALUE, DOUT_EN = 1, go to RD_HOLD; otherwise go to IDLE.
//    - Timed-out write: go to IDLE. A late ACK arriving in IDLE is ignored.
//  - MEM_TIMEOUT_EN undefined: no counter; wait for ACK indefinitely; TIMEOUT_FLAG tied 0.
// TESTING
//  1. Read hit: ROM_ADDR = 24'h012345, ROM_HIT = 1, RD fall; ACK 3 cycles after REQ with RDATA = 8'hA5
//     -> MEM_REQ at cycle 1, MEM_ADDR = 012345, WE = 0; DOUT = A5, DOUT_EN the cycle after ACK, cleared the cycle after RD rise.
//  2. Write: IS_WRITABLE = 1, ROM_ADDR = 24'hE01FF0, WR fall, DIN = 8'h3C at WR rise
//     -> one REQ with WE = 1, ADDR = E01FF0, WDATA = 3C; nothing before WR rise; BUSY clears after ACK.
//  3. Miss and aborted read: RD fall with ROM_HIT = 0 -> no REQ, DOUT_EN = 0.
//     RD rise before ACK on a hit -> REQ completes, DOUT_EN never 1.
//  4. Simultaneous RD and WR fall, both hits -> only a read request is issued. A WR fall while in RD_REQ -> ignored.
//  5. RST_N low while MEM_REQ = 1 and while DOUT_EN = 1 -> both 0 immediately (async). After release, a new read works normally.
//  6. MEM_TIMEOUT_EN, no ACK -> REQ drops after exactly 32 cycles, DOUT = FF with DOUT_EN, TIMEOUT_FLAG = 1 sticky.
//     Without the macro, REQ stays high for 1000 cycles and the flag stays 0.

Source files
------------

// File: rtl/snes_mem_responder.sv
// SNES bus-cycle responder: turns decoded SNES strobes into SRAM0 requests.
// Optional MEM_TIMEOUT_EN adds a request watchdog with open-bus read return.
module snes_mem_responder
`ifdef MEM_TIMEOUT_EN
#(
  parameter int          TIMEOUT_CYCLES = 32,
  parameter logic [7:0]  OPEN_BUS_VALUE = 8'hFF
)
`endif
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SNES_RD_N,
  input  logic        SNES_WR_N,
  input  logic [7:0]  SNES_DIN,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [23:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RDATA,
  output logic [7:0]  SNES_DOUT,
  output logic        SNES_DOUT_EN,
  output logic        BUSY,
  output logic        TIMEOUT_FLAG
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_HOLD,
    WR_WAIT,
    WR_REQ
  } state_t;

  state_t      state, state_nx;
  logic        rd_n_d, wr_n_d;
  logic        rd_fall, rd_rise;
  logic        wr_fall, wr_rise;
  logic        req_q, req_nx;
  logic        we_q, we_nx;
  logic [23:0] addr_q, addr_nx;
  logic [7:0]  wdata_q, wdata_nx;
  logic [7:0]  dout_q, dout_nx;
  logic        den_q, den_nx;
  logic        abort_q, abort_nx;
  logic        rd_gone;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_nx;
  logic          tflag_q, tflag_nx;
  logic          expire;
`endif

  assign rd_fall = rd_n_d & ~SNES_RD_N;
  assign rd_rise = ~rd_n_d & SNES_RD_N;
  assign wr_fall = wr_n_d & ~SNES_WR_N;
  assign wr_rise = ~wr_n_d & SNES_WR_N;

  // SNES released the read before completion: drop the data
  assign rd_gone = abort_q | SNES_RD_N;

`ifdef MEM_TIMEOUT_EN
  assign expire = req_q & ~MEM_ACK & (cnt_q == CNT_LAST);
`endif

  // Next-state and next-value logic for the whole responder
  always_comb begin
    state_nx = state;
    req_nx   = req_q;
    we_nx    = we_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    dout_nx  = dout_q;
    den_nx   = den_q;
    abort_nx = abort_q;
`ifdef MEM_TIMEOUT_EN
    tflag_nx = tflag_q;
`endif
    unique case (state)
      IDLE: begin
        if (rd_fall) begin
          if (ROM_HIT) begin
            addr_nx  = ROM_ADDR;
            req_nx   = 1'b1;
            we_nx    = 1'b0;
            abort_nx = 1'b0;
            state_nx = RD_REQ;
          end
        end else if (wr_fall && IS_WRITABLE) begin
          addr_nx  = ROM_ADDR;
          state_nx = WR_WAIT;
        end
      end
      RD_REQ: begin
        if (rd_rise) abort_nx = 1'b1;
        if (MEM_ACK) begin
          req_nx = 1'b0;
          if (rd_gone) begin
            state_nx = IDLE;
          end else begin
            dout_nx  = MEM_RDATA;
            den_nx   = 1'b1;
            state_nx = RD_HOLD;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (expire) begin
          req_nx   = 1'b0;
          tflag_nx = 1'b1;
          if (rd_gone) begin
            state_nx = IDLE;
          end else begin
            dout_nx  = OPEN_BUS_VALUE;
            den_nx   = 1'b1;
            state_nx = RD_HOLD;
          end
        end
`endif
      end
      RD_HOLD: begin
        if (rd_rise) begin
          den_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      WR_WAIT: begin
        if (wr_rise) begin
          wdata_nx = SNES_DIN;
          req_nx   = 1'b1;
          we_nx    = 1'b1;
          state_nx = WR_REQ;
        end
      end
      WR_REQ: begin
        if (MEM_ACK) begin
          req_nx   = 1'b0;
          state_nx = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (expire) begin
          req_nx   = 1'b0;
          tflag_nx = 1'b1;
          state_nx = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  // Watchdog count: cleared on each request rise, counts unacked cycles
  always_comb begin
    cnt_nx = cnt_q;
    if (req_nx && !req_q) cnt_nx = '0;
    else if (req_q && !MEM_ACK) cnt_nx = cnt_q + CW'(1);
  end

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_nx;
      tflag_q <= tflag_nx;
    end
  end

  assign TIMEOUT_FLAG = tflag_q;
`else
  assign TIMEOUT_FLAG = 1'b0;
`endif

  // State, strobe history and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      rd_n_d  <= 1'b1;
      wr_n_d  <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      den_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_n_d  <= SNES_RD_N;
      wr_n_d  <= SNES_WR_N;
      req_q   <= req_nx;
      we_q    <= we_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      dout_q  <= dout_nx;
      den_q   <= den_nx;
      abort_q <= abort_nx;
    end
  end

  assign MEM_REQ      = req_q;
  assign MEM_WE       = we_q;
  assign MEM_ADDR     = addr_q;
  assign MEM_WDATA    = wdata_q;
  assign SNES_DOUT    = dout_q;
  assign SNES_DOUT_EN = den_q;
  assign BUSY         = (state != IDLE);

endmodule

// File: tb/tb_snes_mem_responder.sv
// Directed bench for snes_mem_responder.
// Covers read, write, miss, abort, priority, reset and the watchdog.
module tb_snes_mem_responder;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        SNES_RD_N, SNES_WR_N;
  logic [7:0]  SNES_DIN;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT, IS_WRITABLE;
  logic        MEM_REQ, MEM_WE;
  logic [23:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic        MEM_ACK;
  logic [7:0]  MEM_RDATA;
  logic [7:0]  SNES_DOUT;
  logic        SNES_DOUT_EN, BUSY, TIMEOUT_FLAG;

  int errors = 0;
  int checks = 0;

  snes_mem_responder dut (
    .CLK(CLK), .RST_N(RST_N),
    .SNES_RD_N(SNES_RD_N), .SNES_WR_N(SNES_WR_N),
    .SNES_DIN(SNES_DIN), .ROM_ADDR(ROM_ADDR),
    .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .SNES_DOUT(SNES_DOUT), .SNES_DOUT_EN(SNES_DOUT_EN),
    .BUSY(BUSY), .TIMEOUT_FLAG(TIMEOUT_FLAG)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ack(input logic [7:0] d);
    MEM_ACK   = 1'b1;
    MEM_RDATA = d;
    tick();
    MEM_ACK   = 1'b0;
    MEM_RDATA = 8'h00;
  endtask

  initial begin
    int n;
    RST_N = 1'b0;
    SNES_RD_N = 1'b1; SNES_WR_N = 1'b1;
    SNES_DIN = '0; ROM_ADDR = '0;
    ROM_HIT = 1'b0; IS_WRITABLE = 1'b0;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    tick(); tick();
    chk("rst_req", MEM_REQ, 0);
    chk("rst_den", SNES_DOUT_EN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_dout", SNES_DOUT, 0);
    chk("rst_flag", TIMEOUT_FLAG, 0);
    RST_N = 1'b1;
    tick();

    // 1: read hit, ACK 3 cycles after REQ
    ROM_ADDR = 24'h012345; ROM_HIT = 1'b1;
    SNES_RD_N = 1'b0;
    tick();
    chk("rd_req", MEM_REQ, 1);
    chk("rd_we", MEM_WE, 0);
    chk("rd_addr", MEM_ADDR, 24'h012345);
    chk("rd_busy", BUSY, 1);
    ROM_ADDR = 24'h000000;
    tick(); tick();
    chk("rd_req_hold", MEM_REQ, 1);
    chk("rd_addr_hold", MEM_ADDR, 24'h012345);
    chk("rd_den_early", SNES_DOUT_EN, 0);
    ack(8'hA5);
    chk("rd_req_drop", MEM_REQ, 0);
    chk("rd_den", SNES_DOUT_EN, 1);
    chk("rd_dout", SNES_DOUT, 8'hA5);
    tick(); tick();
    chk("rd_den_hold", SNES_DOUT_EN, 1);
    SNES_RD_N = 1'b1;
    tick();
    chk("rd_den_clr", SNES_DOUT_EN, 0);
    chk("rd_dout_keep", SNES_DOUT, 8'hA5);
    chk("rd_idle", BUSY, 0);

    // 2: write to save RAM, data sampled at WR rise
    IS_WRITABLE = 1'b1; ROM_ADDR = 24'hE01FF0;
    SNES_WR_N = 1'b0; SNES_DIN = 8'h11;
    tick();
    chk("wr_busy", BUSY, 1);
    chk("wr_noreq", MEM_REQ, 0);
    ROM_ADDR = 24'h123456;
    tick(); tick();
    chk("wr_noreq2", MEM_REQ, 0);
    SNES_DIN = 8'h3C; SNES_WR_N = 1'b1;
    tick();
    chk("wr_req", MEM_REQ, 1);
    chk("wr_we", MEM_WE, 1);
    chk("wr_addr", MEM_ADDR, 24'hE01FF0);
    chk("wr_wdata", MEM_WDATA, 8'h3C);
    SNES_DIN = 8'h00;
    tick();
    chk("wr_wdata_hold", MEM_WDATA, 8'h3C);
    chk("wr_den", SNES_DOUT_EN, 0);
    ack(8'h00);
    chk("wr_req_drop", MEM_REQ, 0);
    chk("wr_idle", BUSY, 0);
    IS_WRITABLE = 1'b0;

    // 3a: read miss
    ROM_HIT = 1'b0; ROM_ADDR = 24'h400000;
    SNES_RD_N = 1'b0;
    tick();
    chk("miss_req", MEM_REQ, 0);
    chk("miss_busy", BUSY, 0);
    tick();
    chk("miss_den", SNES_DOUT_EN, 0);
    SNES_RD_N = 1'b1;
    tick();

    // 3b: aborted read
    ROM_HIT = 1'b1; ROM_ADDR = 24'h008000;
    SNES_RD_N = 1'b0;
    tick();
    chk("ab_req", MEM_REQ, 1);
    SNES_RD_N = 1'b1;
    tick();
    chk("ab_req_hold", MEM_REQ, 1);
    tick();
    ack(8'h77);
    chk("ab_req_drop", MEM_REQ, 0);
    chk("ab_den", SNES_DOUT_EN, 0);
    chk("ab_idle", BUSY, 0);
    tick();
    chk("ab_den2", SNES_DOUT_EN, 0);

    // 4: simultaneous falls, read wins; WR fall in RD_REQ ignored
    IS_WRITABLE = 1'b1; ROM_ADDR = 24'h00ABCD;
    SNES_RD_N = 1'b0; SNES_WR_N = 1'b0;
    tick();
    chk("pri_req", MEM_REQ, 1);
    chk("pri_we", MEM_WE, 0);
    SNES_WR_N = 1'b1;
    tick();
    SNES_WR_N = 1'b0;
    tick();
    chk("pri_we2", MEM_WE, 0);
    ack(8'h42);
    chk("pri_dout", SNES_DOUT, 8'h42);
    SNES_RD_N = 1'b1;
    tick();
    chk("pri_idle", BUSY, 0);
    SNES_WR_N = 1'b1;
    tick(); tick();
    chk("pri_nowr_req", MEM_REQ, 0);
    chk("pri_nowr_busy", BUSY, 0);
    IS_WRITABLE = 1'b0;

    // 5: async reset mid-request and mid-drive
    ROM_ADDR = 24'h010000;
    SNES_RD_N = 1'b0;
    tick();
    chk("r5_req", MEM_REQ, 1);
    #2 RST_N = 1'b0; SNES_RD_N = 1'b1;
    #1;
    chk("r5_req_async", MEM_REQ, 0);
    chk("r5_busy_async", BUSY, 0);
    tick();
    RST_N = 1'b1;
    tick();
    SNES_RD_N = 1'b0;
    tick();
    ack(8'h99);
    chk("r5_den", SNES_DOUT_EN, 1);
    #2 RST_N = 1'b0; SNES_RD_N = 1'b1;
    #1;
    chk("r5_den_async", SNES_DOUT_EN, 0);
    chk("r5_dout_async", SNES_DOUT, 0);
    tick();
    RST_N = 1'b1;
    tick();
    ROM_ADDR = 24'h020304;
    SNES_RD_N = 1'b0;
    tick();
    chk("r5_new_req", MEM_REQ, 1);
    chk("r5_new_addr", MEM_ADDR, 24'h020304);
    ack(8'h5A);
    chk("r5_new_dout", SNES_DOUT, 8'h5A);
    chk("r5_new_den", SNES_DOUT_EN, 1);
    SNES_RD_N = 1'b1;
    tick();

    // 6: watchdog
    SNES_RD_N = 1'b0;
    tick();
    n = 0;
`ifdef MEM_TIMEOUT_EN
    while (MEM_REQ && n < 100) begin
      n++;
      tick();
    end
    chk("to_len", n, 32);
    chk("to_req", MEM_REQ, 0);
    chk("to_den", SNES_DOUT_EN, 1);
    chk("to_dout", SNES_DOUT, 8'hFF);
    chk("to_flag", TIMEOUT_FLAG, 1);
    SNES_RD_N = 1'b1;
    tick();
    chk("to_den_clr", SNES_DOUT_EN, 0);
    ack(8'h12);
    chk("to_late_busy", BUSY, 0);
    chk("to_late_req", MEM_REQ, 0);
    tick();
    chk("to_sticky", TIMEOUT_FLAG, 1);
`else
    for (int i = 0; i < 1000; i++) begin
      if (MEM_REQ) n++;
      tick();
    end
    chk("nto_len", n, 1000);
    chk("nto_req", MEM_REQ, 1);
    chk("nto_flag", TIMEOUT_FLAG, 0);
    ack(8'h66);
    chk("nto_dout", SNES_DOUT, 8'h66);
    SNES_RD_N = 1'b1;
    tick();
    chk("nto_idle", BUSY, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
